md_unit: RTL and testbench

//   Multiply/divide responder at the far end of the EX-stage start/BUSY handshake.
//   EX issues a one-cycle start with operands; md_unit holds BUSY for a fixed latency, then commits HI/LO.
//   HI/LO feed mfhi/mflo back into the EX forwarding path. The hazard unit stalls on BUSY.

---
 rtl/md_pkg.sv | 51 +++++
 rtl/md_result_calc.sv | 75 +++++++
 rtl/md_unit.sv | 135 +++++++++++++
 tb/tb_md_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Optional MD_MADD_EN enables the madd/msub accumulate opcodes.
package md_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MADD  = 4'd7,
      MD_MADDU = 4'd8,
      MD_MSUB  = 4'd9,
      MD_MSUBU = 4'd10
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   function automatic int md_cnt_w(input int a, input int b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

   localparam int MD_CNT_W = md_cnt_w(MD_MULT_CYCLES, MD_DIV_CYCLES);

   // Accumulate opcodes only join the multiply class when the feature is built in.
   function automatic logic md_is_mul(input md_op_t op);
      case (op)
         MD_MULT, MD_MULTU: return 1'b1;
`ifdef MD_MADD_EN
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic md_is_div(input md_op_t op);
      case (op)
         MD_DIV, MD_DIVU: return 1'b1;
         default:         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational HI/LO result for one md operation; res_valid drops on divide by zero.
// Accumulate variants are computed only when MD_MADD_EN is defined.
module md_result_calc
   import md_pkg::*;
(
   input  logic [3:0]  md_op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        res_valid
);

   logic [63:0] prod_s_s;
   logic [63:0] prod_u_s;
   logic        div_signed_s;
   logic        a_neg_s;
   logic        b_neg_s;
   logic [31:0] mag_a_s;
   logic [31:0] mag_b_s;
   logic [31:0] quo_s;
   logic [31:0] rem_s;

   // Products: sign-extending to 64 bits makes the low 64 product bits correct for signed operands.
   always_comb begin
      prod_s_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
      prod_u_s = {32'd0, rs} * {32'd0, rt};
   end

   // Divide on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow.
   always_comb begin
      div_signed_s = (md_op_t'(md_op) == MD_DIV);
      a_neg_s      = div_signed_s & rs[31];
      b_neg_s      = div_signed_s & rt[31];
      mag_a_s      = a_neg_s ? (32'd0 - rs) : rs;
      mag_b_s      = b_neg_s ? (32'd0 - rt) : rt;
      if (rt == 32'd0) begin
         quo_s = 32'd0;
         rem_s = 32'd0;
      end else begin
         quo_s = mag_a_s / mag_b_s;
         rem_s = mag_a_s % mag_b_s;
      end
   end

   // Result select; ops with no arithmetic pass the current HI/LO through.
   always_comb begin
      res_hi    = hi;
      res_lo    = lo;
      res_valid = 1'b1;
      case (md_op_t'(md_op))
         MD_MULT:  {res_hi, res_lo} = prod_s_s;
         MD_MULTU: {res_hi, res_lo} = prod_u_s;
         MD_DIV, MD_DIVU: begin
            res_valid = (rt != 32'd0);
            res_lo    = (a_neg_s ^ b_neg_s) ? (32'd0 - quo_s) : quo_s;
            res_hi    = a_neg_s ? (32'd0 - rem_s) : rem_s;
         end
`ifdef MD_MADD_EN
         MD_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s_s;
         MD_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u_s;
         MD_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s_s;
         MD_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u_s;
`endif
         default: begin
            res_hi    = hi;
            res_lo    = lo;
            res_valid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: fixed-latency BUSY handshake with EX, HI/LO commit at end of RUN.
// Build with MD_MADD_EN to enable madd/maddu/msub/msubu.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_W = md_cnt_w(MULT_CYCLES, DIV_CYCLES);

   md_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic [31:0] res_hi_s, res_lo_s;
   logic        res_valid_s;
   logic        is_mul_s, is_div_s, launch_s;

   md_result_calc u_calc (
      .md_op     (md_op),
      .rs        (rs),
      .rt        (rt),
      .hi        (hi_q),
      .lo        (lo_q),
      .res_hi    (res_hi_s),
      .res_lo    (res_lo_s),
      .res_valid (res_valid_s)
   );

   // State and datapath registers; reset drops any pending result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         pend_hi_q    <= 32'd0;
         pend_lo_q    <= 32'd0;
         pend_valid_q <= 1'b0;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_hi_q    <= pend_hi_d;
         pend_lo_q    <= pend_lo_d;
         pend_valid_q <= pend_valid_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         busy_q       <= busy_d;
      end
   end

   // Next state: only an idle start of a long op enters RUN; RUN ends when the counter hits zero.
   always_comb begin
      is_mul_s = md_is_mul(md_op_t'(md_op));
      is_div_s = md_is_div(md_op_t'(md_op));
      launch_s = (state_q == ST_IDLE) && start && (is_mul_s || is_div_s);
      state_d  = state_q;
      case (state_q)
         ST_IDLE: begin
            if (launch_s) state_d = ST_RUN;
            else          state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (cnt_q == {CNT_W{1'b0}}) state_d = ST_IDLE;
            else                        state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: latch pending result at launch, mthi/mtlo only while idle, commit on the last RUN cycle.
   always_comb begin
      cnt_d        = cnt_q;
      pend_hi_d    = pend_hi_q;
      pend_lo_d    = pend_lo_q;
      pend_valid_d = pend_valid_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (launch_s) begin
               cnt_d        = is_mul_s ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
               pend_hi_d    = res_hi_s;
               pend_lo_d    = res_lo_s;
               pend_valid_d = res_valid_s;
            end else if (start && (md_op_t'(md_op) == MD_MTHI)) begin
               hi_d = rs;
            end else if (start && (md_op_t'(md_op) == MD_MTLO)) begin
               lo_d = rs;
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_RUN: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               if (pend_valid_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end else begin
                  hi_d = hi_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: cnt_d = {CNT_W{1'b0}};
      endcase
   end

   // Output decode: busy tracks the RUN state from the cycle after launch.
   always_comb begin
      busy_d = (state_d == ST_RUN);
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table plus multi-cycle corner sequences.
// Honours MD_MADD_EN for the accumulate sequence.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] m_hi, m_lo;

   typedef struct {
      string       nm;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          ncyc;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   typedef struct {
      int          ncyc;
      logic [31:0] eh;
      logic [31:0] el;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[14];

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .rs    (rs),
      .rt    (rt),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
      end
   endtask

   // Issue one op, optionally inject a second start on busy cycle inj_at, then score the outcome.
   task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int ncyc, input logic [31:0] eh,
                         input logic [31:0] el, input int inj_at, input logic [3:0] iop);
      exp_t e;
      int   cyc;
      e.ncyc = ncyc; e.eh = eh; e.el = el;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1; md_op = op; rs = a; rt = b;
      @(negedge clk);
      start = 1'b0; md_op = 4'($urandom); rs = $urandom; rt = $urandom;
      cyc = 0;
      while (busy === 1'b1 && cyc < 64) begin
         cyc++;
         if (cyc == 1) begin
            check({nm, " hold_hi"}, hi, m_hi);
            check({nm, " hold_lo"}, lo, m_lo);
         end
         if (cyc == inj_at) begin
            start = 1'b1; md_op = iop; rs = 32'hDEADBEEF; rt = 32'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      e = sb.pop_front();
      check({nm, " busy_cycles"}, 32'(cyc), 32'(e.ncyc));
      check({nm, " hi"}, hi, e.eh);
      check({nm, " lo"}, lo, e.el);
      m_hi = e.eh;
      m_lo = e.el;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{"mult_neg",    4'd1,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{"multu_big",   4'd2,  32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
      vecs[2]  = '{"divu_100_7",  4'd4,  32'd100,      32'd7,        10, 32'd2,        32'd14};
      vecs[3]  = '{"div_m7_2",    4'd3,  32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{"div_7_m2",    4'd3,  32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
      vecs[5]  = '{"div_ovf",     4'd3,  32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000};
      vecs[6]  = '{"mult_minsq",  4'd1,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'd0};
      vecs[7]  = '{"multu_max",   4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'd1};
      vecs[8]  = '{"divu_max_2",  4'd4,  32'hFFFFFFFF, 32'd2,        10, 32'd1,        32'h7FFFFFFF};
      vecs[9]  = '{"mthi",        4'd5,  32'h00001234, 32'd9,        0,  32'h00001234, 32'h7FFFFFFF};
      vecs[10] = '{"mtlo",        4'd6,  32'h00005678, 32'd9,        0,  32'h00001234, 32'h00005678};
      vecs[11] = '{"none",        4'd0,  32'h11111111, 32'd5,        0,  32'h00001234, 32'h00005678};
      vecs[12] = '{"op13",        4'd13, 32'h22222222, 32'd5,        0,  32'h00001234, 32'h00005678};
      vecs[13] = '{"mult_m7_m2",  4'd1,  32'hFFFFFFF9, 32'hFFFFFFFE, 5,  32'd0,        32'd14};

      reset = 1'b1; start = 1'b0; md_op = 4'd0; rs = 32'd0; rt = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ncyc,
                vecs[i].eh, vecs[i].el, 0, 4'd0);
      end

      // mtlo injected during RUN must be dropped
      run_op("mult_mtlo_ign", 4'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6, 2, 4'd6);

      // divide by zero keeps HI/LO; a second start on busy cycle 3 must not relaunch
      run_op("set_hi", 4'd5, 32'h0000000A, 32'd0, 0, 32'h0000000A, 32'd6, 0, 4'd0);
      run_op("set_lo", 4'd6, 32'h0000000B, 32'd0, 0, 32'h0000000A, 32'h0000000B, 0, 4'd0);
      run_op("div0", 4'd3, 32'h00000055, 32'd0, 10, 32'h0000000A, 32'h0000000B, 3, 4'd4);
      @(negedge clk);
      check("div0 no_relaunch", {31'd0, busy}, 32'd0);

      // reset on busy cycle 4 of a DIVU clears everything and leaves nothing to commit
      @(negedge clk);
      start = 1'b1; md_op = 4'd4; rs = 32'd100; rt = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("rst_mid busy", {31'd0, busy}, 32'd0);
      check("rst_mid hi", hi, 32'd0);
      check("rst_mid lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("rst_mid late_busy", {31'd0, busy}, 32'd0);
      check("rst_mid late_hi", hi, 32'd0);
      check("rst_mid late_lo", lo, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;

      run_op("acc_hi", 4'd5, 32'd0, 32'd0, 0, 32'd0, 32'd0, 0, 4'd0);
      run_op("acc_lo", 4'd6, 32'hFFFFFFFF, 32'd0, 0, 32'd0, 32'hFFFFFFFF, 0, 4'd0);
`ifdef MD_MADD_EN
      run_op("maddu", 4'd8, 32'd1, 32'd1, 5, 32'd1, 32'd0, 0, 4'd0);
      run_op("msub", 4'd9, 32'd2, 32'hFFFFFFFF, 5, 32'd1, 32'd2, 0, 4'd0);
`else
      run_op("maddu_off", 4'd8, 32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF, 0, 4'd0);
      run_op("msub_off", 4'd9, 32'd2, 32'hFFFFFFFF, 0, 32'd0, 32'hFFFFFFFF, 0, 4'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
